vram_arbiter: RTL and testbench

- Request/grant arbiter that shares the single-port 640-bit x 512-row VRAM between up to 8 client modules (renderers, scroll/clear engines, readback).
- Replaces fixed time-slicing with work-conserving round-robin: idle ports cost no VRAM cycles.
- Registers the winning command onto the VRAM port and routes read data back to the issuing port with a per-port valid strobe.

---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 31 +++
 rtl/vram_arbiter.sv | 86 ++++++++
 tb/tb_vram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM geometry, row/index types and the read-return tag.
package vram_pkg;

  localparam int VRAM_ADDR_W      = 9;
  localparam int VRAM_DATA_W      = 640;
  localparam int VRAM_PORTS       = 8;
  localparam int VRAM_PORT_IDX_W  = 4;

  typedef logic [VRAM_DATA_W-1:0]     vram_row_t;
  typedef logic [VRAM_PORT_IDX_W-1:0] vram_port_idx_t;

  typedef struct packed {
    logic           valid;
    vram_port_idx_t port;
  } rd_tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Client request/grant/readback bundle plus the single VRAM port it arbitrates onto.
interface vram_arbiter_if #(
  parameter int N_PORTS = 8,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 640
);
  logic [N_PORTS-1:0]        req;
  logic [N_PORTS-1:0]        req_we;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*DATA_W-1:0] req_wdata;
  logic [N_PORTS-1:0]        gnt;
  logic [N_PORTS-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [ADDR_W-1:0]         vram_addr;
  logic [DATA_W-1:0]         vram_din;
  logic                      vram_wea;
  logic [DATA_W-1:0]         vram_dout;

  modport slave (
    input  req, req_we, req_addr, req_wdata, vram_dout,
    output gnt, rd_valid, rd_data, vram_addr, vram_din, vram_wea
  );

  modport master (
    output req, req_we, req_addr, req_wdata, vram_dout,
    input  gnt, rd_valid, rd_data, vram_addr, vram_din, vram_wea
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first requester at or after ptr, wrapping.
// Purely combinational; the request vector is duplicated so the wrap becomes a plain lowest-set-bit search.
module rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({(2*N){1'b1}} << ptr);
    // Isolate the lowest set bit; the upper copy supplies the wrapped-around ports.
    first  = masked & ~(masked - (2*N)'(1));
    gnt    = first[N-1:0] | first[2*N-1:N];
    any    = |req;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Work-conserving round-robin arbiter sharing one VRAM port; grant is combinational, command registered next edge.
// Read data returns RD_LATENCY+1 cycles after the grant edge through a non-stalling tag pipeline; no backpressure.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int N_PORTS    = VRAM_PORTS,
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  vram_arbiter_if.slave bus
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win;
  logic [N_PORTS-1:0] gnt;
  logic               any;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  rd_tag_t            push_tag;
  rd_tag_t [RD_LATENCY:0] pipe;

  rr_pick #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

  assign bus.gnt = gnt;

  always_comb begin
    sel_addr       = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
    sel_wdata      = bus.req_wdata[int'(win)*DATA_W +: DATA_W];
    sel_we         = bus.req_we[win];
    push_tag.valid = any && !sel_we;
    push_tag.port  = vram_port_idx_t'(win);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      bus.vram_addr <= '0;
      bus.vram_din  <= '0;
      bus.vram_wea  <= 1'b0;
    end else if (any) begin
      bus.vram_addr <= sel_addr;
      bus.vram_din  <= sel_wdata;
      bus.vram_wea  <= sel_we;
      ptr          <= (int'(win) == N_PORTS - 1) ? '0 : win + 1'b1;
    end else begin
      bus.vram_wea  <= 1'b0;
    end
  end

  // Tag rides alongside the VRAM's own read latency, then one more stage to register rd_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe         <= '0;
      bus.rd_valid <= '0;
      bus.rd_data  <= '0;
    end else begin
      pipe[0] <= push_tag;
      for (int j = 1; j <= RD_LATENCY; j++) begin
        pipe[j] <= pipe[j-1];
      end
      if (pipe[RD_LATENCY].valid) begin
        bus.rd_valid <= N_PORTS'(1) << pipe[RD_LATENCY].port;
        bus.rd_data  <= bus.vram_dout;
      end else begin
        bus.rd_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized and directed bench for vram_arbiter against a queue-based round-robin reference model.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int NP  = 8;
  localparam int AW  = 9;
  localparam int DW  = 640;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(
    .N_PORTS    (NP),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_LATENCY (RDL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // VRAM stand-in: read data is a pure function of the address, delayed RDL cycles.
  function automatic vram_row_t row_of(input logic [AW-1:0] a);
    if (a == 9'h010) return {80{8'h55}};
    return {20{({23'h5A3C1, a} ^ 32'h9E3779B9)}};
  endfunction

  vram_row_t vpipe [RDL];
  always @(posedge clk) begin
    vpipe[0] <= row_of(bus.vram_addr);
    for (int j = 1; j < RDL; j++) vpipe[j] <= vpipe[j-1];
  end
  assign bus.vram_dout = vpipe[RDL-1];

  typedef struct {
    int        due;
    int        port;
    vram_row_t data;
  } rd_ev_t;

  rd_ev_t          rq[$];
  int              ptr_m;
  int              cyc;
  int              exp_k;
  logic [NP-1:0]   exp_gnt;
  logic [NP-1:0]   exp_rv;
  logic            exp_wea;
  logic [AW-1:0]   exp_addr;
  vram_row_t       exp_din;
  vram_row_t       exp_rd;
  int              nvec;
  int              nerr;

  function automatic vram_row_t rand_row();
    vram_row_t r;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic idle();
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input vram_row_t d);
    bus.req[p]                = 1'b1;
    bus.req_we[p]             = we;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_wdata[p*DW +: DW] = d;
  endtask

  // Expected outputs for the current cycle, from the round-robin rule and the pending-read queue.
  task automatic sample();
    #1;
    if (!rst) begin
      ptr_m = 0; exp_wea = 1'b0; exp_addr = '0; exp_din = '0; exp_rd = '0;
      rq.delete();
    end
    exp_k = -1;
    for (int i = 0; i < NP; i++) begin
      if (exp_k < 0 && bus.req[(ptr_m + i) % NP]) exp_k = (ptr_m + i) % NP;
    end
    exp_gnt = '0;
    if (exp_k >= 0) exp_gnt[exp_k] = 1'b1;
    exp_rv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rv[rq[0].port] = 1'b1;
      exp_rd = rq[0].data;
      void'(rq.pop_front());
    end
  endtask

  task automatic commit();
    if (rst) begin
      if (exp_k >= 0) begin
        exp_wea  = bus.req_we[exp_k];
        exp_addr = bus.req_addr[exp_k*AW +: AW];
        exp_din  = bus.req_wdata[exp_k*DW +: DW];
        if (!exp_wea) rq.push_back('{due: cyc + RDL + 2, port: exp_k, data: row_of(exp_addr)});
        ptr_m = (exp_k + 1) % NP;
      end else begin
        exp_wea = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    sample(); commit();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      if (bus.vram_wea !== 1'b0) begin nerr++; $display("FAIL reset_wea got=%b exp=0", bus.vram_wea); end nvec++;
      if (bus.rd_valid !== '0) begin nerr++; $display("FAIL reset_rdv got=%b exp=0", bus.rd_valid); end nvec++;
      commit();
    end
    rst = 1'b1;
    sample();
    if (bus.gnt !== 8'h00) begin nerr++; $display("FAIL idle_gnt got=%b exp=0", bus.gnt); end nvec++;
    if (bus.vram_wea !== 1'b0) begin nerr++; $display("FAIL idle_wea got=%b exp=0", bus.vram_wea); end nvec++;
    if (bus.rd_valid !== '0) begin nerr++; $display("FAIL idle_rdv got=%b exp=0", bus.rd_valid); end nvec++;
    if (bus.vram_addr !== '0) begin nerr++; $display("FAIL idle_addr got=%h exp=0", bus.vram_addr); end nvec++;
    if (bus.rd_data !== '0) begin nerr++; $display("FAIL idle_rdd got=%h exp=0", bus.rd_data); end nvec++;
    commit();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(p), rand_row());
    sample();
    if (bus.gnt !== 8'h01) begin nerr++; $display("FAIL ptr0_gnt got=%b exp=00000001", bus.gnt); end nvec++;
    commit();
    idle();
    sample(); commit();
  endtask

  task automatic test_single_writer();
    vram_row_t wd;
    wd = {20{32'hDEADBEEF}};
    do_reset();
    idle();
    set_port(3, 1'b1, 9'h1A5, wd);
    sample();
    if (bus.gnt !== 8'h08) begin nerr++; $display("FAIL wr_gnt got=%b exp=00001000", bus.gnt); end nvec++;
    commit();
    idle();
    sample();
    if (bus.vram_wea !== 1'b1) begin nerr++; $display("FAIL wr_wea got=%b exp=1", bus.vram_wea); end nvec++;
    if (bus.vram_addr !== 9'h1A5) begin nerr++; $display("FAIL wr_addr got=%h exp=1a5", bus.vram_addr); end nvec++;
    if (bus.vram_din !== wd) begin nerr++; $display("FAIL wr_din got=%h exp=%h", bus.vram_din, wd); end nvec++;
    commit();
    set_port(2, 1'b1, 9'h002, rand_row());
    set_port(5, 1'b1, 9'h005, rand_row());
    sample();
    if (bus.gnt !== 8'h20) begin nerr++; $display("FAIL wr_ptr4_gnt got=%b exp=00100000", bus.gnt); end nvec++;
    commit();
    idle();
    sample();
    if (bus.vram_wea !== 1'b1 || bus.vram_addr !== 9'h005) begin
      nerr++; $display("FAIL wr_ptr4_cmd got=%b/%h exp=1/005", bus.vram_wea, bus.vram_addr);
    end nvec++;
    commit();
    sample();
    if (bus.vram_wea !== 1'b0) begin nerr++; $display("FAIL wr_idle_wea got=%b exp=0", bus.vram_wea); end nvec++;
    commit();
  endtask

  task automatic test_contention();
    int served [NP];
    logic [NP-1:0] eg;
    logic [AW-1:0] ea;
    for (int p = 0; p < NP; p++) served[p] = 0;
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(p), rand_row());
    for (int i = 0; i < 2 * NP; i++) begin
      sample();
      eg = '0;
      eg[i % NP] = 1'b1;
      if (bus.gnt !== eg) begin nerr++; $display("FAIL cont_gnt%0d got=%b exp=%b", i, bus.gnt, eg); end nvec++;
      if (i > 0) begin
        ea = AW'((i - 1) % NP);
        if (bus.vram_addr !== ea || bus.vram_wea !== 1'b1) begin
          nerr++; $display("FAIL cont_cmd%0d got=%h/%b exp=%h/1", i, bus.vram_addr, bus.vram_wea, ea);
        end nvec++;
      end
      for (int p = 0; p < NP; p++) if (bus.gnt[p]) served[p]++;
      commit();
    end
    for (int p = 0; p < NP; p++) begin
      if (served[p] !== 2) begin nerr++; $display("FAIL cont_served%0d got=%0d exp=2", p, served[p]); end nvec++;
    end
    idle();
    sample(); commit();
  endtask

  task automatic test_read_return();
    logic [NP-1:0] erv;
    idle();
    set_port(5, 1'b0, 9'h010, '0);
    sample();
    if (bus.gnt !== 8'h20) begin nerr++; $display("FAIL rd_gnt got=%b exp=00100000", bus.gnt); end nvec++;
    commit();
    idle();
    for (int d = 1; d <= RDL + 4; d++) begin
      sample();
      erv = (d == RDL + 2) ? 8'h20 : 8'h00;
      if (bus.rd_valid !== erv) begin nerr++; $display("FAIL rd_valid_d%0d got=%b exp=%b", d, bus.rd_valid, erv); end nvec++;
      if (d == RDL + 2 && bus.rd_data !== {80{8'h55}}) begin
        nerr++; $display("FAIL rd_data got=%h exp=55..55", bus.rd_data);
      end nvec++;
      commit();
    end
  endtask

  task automatic test_interleaved();
    logic [NP-1:0] erv;
    idle();
    set_port(2, 1'b0, 9'h033, '0);
    sample(); commit();
    idle();
    set_port(6, 1'b0, 9'h0C4, '0);
    sample(); commit();
    idle();
    for (int d = 1; d <= RDL + 4; d++) begin
      sample();
      erv = (d == RDL + 1) ? 8'h04 : (d == RDL + 2) ? 8'h40 : 8'h00;
      if (bus.rd_valid !== erv) begin nerr++; $display("FAIL il_valid_d%0d got=%b exp=%b", d, bus.rd_valid, erv); end nvec++;
      if (d == RDL + 1 && bus.rd_data !== row_of(9'h033)) begin
        nerr++; $display("FAIL il_data2 got=%h exp=%h", bus.rd_data, row_of(9'h033));
      end nvec++;
      if (d == RDL + 2 && bus.rd_data !== row_of(9'h0C4)) begin
        nerr++; $display("FAIL il_data6 got=%h exp=%h", bus.rd_data, row_of(9'h0C4));
      end nvec++;
      commit();
    end
  endtask

  task automatic test_reset_mid_read();
    idle();
    set_port(1, 1'b0, 9'h0AA, '0);
    sample(); commit();
    idle();
    rst = 1'b0;
    sample();
    if (bus.rd_valid !== '0 || bus.vram_wea !== 1'b0) begin
      nerr++; $display("FAIL mid_rst_out got=%b/%b exp=0/0", bus.rd_valid, bus.vram_wea);
    end nvec++;
    commit();
    set_port(5, 1'b1, 9'h055, rand_row());
    sample();
    if (bus.gnt !== 8'h20) begin nerr++; $display("FAIL mid_rst_gnt got=%b exp=00100000", bus.gnt); end nvec++;
    commit();
    idle();
    sample();
    if (bus.vram_wea !== 1'b0) begin nerr++; $display("FAIL mid_rst_noreg got=%b exp=0", bus.vram_wea); end nvec++;
    commit();
    rst = 1'b1;
    for (int d = 0; d < RDL + 4; d++) begin
      sample();
      if (bus.rd_valid !== '0) begin nerr++; $display("FAIL mid_rst_ghost%0d got=%b exp=0", d, bus.rd_valid); end nvec++;
      commit();
    end
    set_port(3, 1'b1, 9'h003, rand_row());
    set_port(6, 1'b1, 9'h006, rand_row());
    sample();
    if (bus.gnt !== 8'h08) begin nerr++; $display("FAIL mid_rst_first got=%b exp=00001000", bus.gnt); end nvec++;
    commit();
    idle();
    sample(); commit();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1) set_port(p, $urandom_range(0, 1) == 1, AW'($urandom()), rand_row());
      end
      rst = ($urandom_range(0, 99) != 0);
      sample();
      if (bus.gnt !== exp_gnt) begin nerr++; $display("FAIL rnd_gnt c%0d got=%b exp=%b", c, bus.gnt, exp_gnt); end nvec++;
      if (bus.vram_wea !== exp_wea) begin nerr++; $display("FAIL rnd_wea c%0d got=%b exp=%b", c, bus.vram_wea, exp_wea); end nvec++;
      if (bus.vram_addr !== exp_addr) begin nerr++; $display("FAIL rnd_addr c%0d got=%h exp=%h", c, bus.vram_addr, exp_addr); end nvec++;
      if (bus.vram_din !== exp_din) begin nerr++; $display("FAIL rnd_din c%0d got=%h exp=%h", c, bus.vram_din, exp_din); end nvec++;
      if (bus.rd_valid !== exp_rv) begin nerr++; $display("FAIL rnd_rdv c%0d got=%b exp=%b", c, bus.rd_valid, exp_rv); end nvec++;
      if (bus.rd_data !== exp_rd) begin nerr++; $display("FAIL rnd_rdd c%0d got=%h exp=%h", c, bus.rd_data, exp_rd); end nvec++;
      commit();
    end
    idle();
    rst = 1'b1;
    for (int d = 0; d < RDL + 3; d++) begin
      sample();
      if (bus.rd_valid !== exp_rv) begin nerr++; $display("FAIL drain_rdv%0d got=%b exp=%b", d, bus.rd_valid, exp_rv); end nvec++;
      if (bus.rd_data !== exp_rd) begin nerr++; $display("FAIL drain_rdd%0d got=%h exp=%h", d, bus.rd_data, exp_rd); end nvec++;
      commit();
    end
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; ptr_m = 0;
    exp_wea = 1'b0; exp_addr = '0; exp_din = '0; exp_rd = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_single_writer();
    test_contention();
    test_read_return();
    test_interleaved();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
